pipe_hazard_fwd: RTL



---
 rtl/pipe_hazard_fwd.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_fwd.sv
// Hazard and forwarding controller for the in-order pipeline: tracks destination registers of
// every post-decode stage, raises the load-use stall and registers per-operand EX forward selects.
module pipe_hazard_fwd #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned SEL_W  = $clog2(DEPTH),
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pipe_en_i,
    input  logic                     id_valid_i,
    input  logic [NSRC*REG_AW-1:0]   id_src_i,
    input  logic [NSRC-1:0]          id_src_used_i,
    input  logic [REG_AW-1:0]        id_rd_i,
    input  logic                     id_regwrite_i,
    input  logic                     id_memread_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [NSRC*SEL_W-1:0]    ex_fwd_sel_o,
    output logic [DEPTH-1:0]         stage_valid_o,
    output logic [DEPTH*REG_AW-1:0]  stage_rd_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0]                 rw_q, rw_d;
    logic [DEPTH-1:0]                 mr_q, mr_d;
    logic [DEPTH-1:0][REG_AW-1:0]     rd_q, rd_d;
    logic [NSRC-1:0][SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;

    logic [DEPTH-1:0]                 live;
    logic [NSRC-1:0][SEL_W-1:0]       sel_match;
    logic                             hazard;
    logic                             issue;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            live[k] = valid_q[k] & rw_q[k] & (rd_q[k] != '0);
        end
    end

    // Only a load sitting in EX can stall; older loads are reachable by forwarding.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (id_src_used_i[s] && live[0] && mr_q[0] &&
                (rd_q[0] == id_src_i[s*REG_AW +: REG_AW])) begin
                hazard = 1'b1;
            end
        end
    end

    assign stall_o = ~flush_i & id_valid_i & hazard;
    assign issue   = id_valid_i & ~flush_i & ~stall_o;

    // Scan oldest to youngest so the youngest match overwrites; the oldest entry is excluded.
    always_comb begin
        sel_match = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (live[k] && (rd_q[k] == id_src_i[s*REG_AW +: REG_AW])) begin
                    sel_match[s] = SEL_W'(k + 1);
                end
            end
            if (!(issue && id_src_used_i[s])) begin
                sel_match[s] = '0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (pipe_en_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                rw_d[k]    = rw_q[k-1];
                mr_d[k]    = mr_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[0] = issue;
            rw_d[0]    = issue & id_regwrite_i;
            mr_d[0]    = issue & id_memread_i;
            rd_d[0]    = issue ? id_rd_i : '0;
            sel_d      = sel_match;
            if (stall_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            rw_q    <= '0;
            mr_q    <= '0;
            rd_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        stage_rd_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_rd_o[k*REG_AW +: REG_AW] = valid_q[k] ? rd_q[k] : '0;
        end
    end

    assign stage_valid_o = valid_q;
    assign ex_fwd_sel_o  = sel_q;
    assign stall_cnt_o   = cnt_q;

endmodule
